// File: rtl/uram_bank_pipe.sv
// Multi-slice URAM bank with per-slice write masks, a pipelined read path and
// a whole-bank zero-fill sequencer.
//
// state | meaning
// IDLE  | accepting requests; init_start launches a fill
// INIT  | writing zero to one address per cycle, requests blocked
module uram_bank_pipe #(
    parameter  int NUM_SLICES  = 3,
    parameter  int SLICE_WIDTH = 72,
    parameter  int ADDR_WIDTH  = 12,
    parameter  int RD_LAT      = 2,
    localparam int W           = NUM_SLICES * SLICE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_SLICES-1:0] req_wmask,
    input  logic [W-1:0]          req_wdata,
    output logic                  rsp_valid,
    output logic [W-1:0]          rsp_data,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, INIT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    init_last;
    logic                    done_q;
    logic                    wr_acc;
    logic                    rd_acc;

    logic [W-1:0]            mem [DEPTH];
    logic [RD_LAT-1:0]       pipe_vld;
    logic [W-1:0]            pipe_dat [RD_LAT];

    assign init_last = (init_cnt == {ADDR_WIDTH{1'b1}});
    assign wr_acc    = req_valid && req_ready && req_we;
    assign rd_acc    = req_valid && req_ready && !req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (init_start) state_nxt = INIT;
            INIT:    if (init_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so nothing is offered while reset is held
    always_comb begin
        init_busy = (state == INIT);
        req_ready = rst_n && (state == IDLE) && !init_start;
        init_done = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == INIT) && init_last;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset so it maps onto URAM
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_SLICES; i++) begin
                if (req_wmask[i]) begin
                    mem[req_addr][i*SLICE_WIDTH +: SLICE_WIDTH] <= req_wdata[i*SLICE_WIDTH +: SLICE_WIDTH];
                end
            end
        end
    end

    // Data stages only load behind a valid, so the output word holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= mem[req_addr];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_dat[k] <= pipe_dat[k-1];
                end
            end
        end
    end

    assign rsp_valid = pipe_vld[RD_LAT-1];
    assign rsp_data  = pipe_dat[RD_LAT-1];

endmodule

// File: tb/tb_uram_bank_pipe.sv
// Scoreboard bench for uram_bank_pipe: a word-level memory model predicts read
// data and response cycle; a negedge monitor checks every response.
module tb_uram_bank_pipe;

    localparam int NS    = 3;
    localparam int SW    = 72;
    localparam int AW    = 12;
    localparam int RL    = 2;
    localparam int W     = NS * SW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NS-1:0] req_wmask = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          init_start = 1'b0;
    logic          init_busy;
    logic          init_done;

    uram_bank_pipe #(
        .NUM_SLICES (NS),
        .SLICE_WIDTH(SW),
        .ADDR_WIDTH (AW),
        .RD_LAT     (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_start(init_start),
        .init_busy (init_busy),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  data;
        logic [NS-1:0] kmask;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  mdl_mem   [DEPTH];
    logic [NS-1:0] mdl_known [DEPTH];
    logic [W-1:0]  hold_ref = '0;
    logic [NS-1:0] hold_km  = '1;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slice_mask(input logic [NS-1:0] k);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < NS; i++) m[i*SW +: SW] = {SW{k[i]}};
        return m;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    // Monitor: every response must match the head of the scoreboard, on time
    initial begin
        exp_t         e;
        logic [W-1:0] m;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_ref = '0;
                hold_km  = '1;
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("rsp_missed", W'(cyc), W'(sb[0].due));
                    void'(sb.pop_front());
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", W'(rsp_valid), W'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_time", W'(cyc), W'(e.due));
                        m = slice_mask(e.kmask);
                        chk("rsp_data", rsp_data & m, e.data & m);
                        hold_ref = e.data;
                        hold_km  = e.kmask;
                    end
                end else begin
                    m = slice_mask(hold_km);
                    chk("rsp_hold", rsp_data & m, hold_ref & m);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [NS-1:0] mk, input logic [W-1:0] d);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wmask = mk;
        req_wdata = d;
        @(negedge clk);
        chk("req_ready", W'(req_ready), W'(1));
        if (we) begin
            for (int i = 0; i < NS; i++) begin
                if (mk[i]) mdl_mem[a][i*SW +: SW] = d[i*SW +: SW];
            end
            mdl_known[a] = mdl_known[a] | mk;
        end else begin
            e.data  = mdl_mem[a];
            e.kmask = mdl_known[a];
            e.due   = cyc + RL;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        sb.delete();
        hold_ref = '0;
        hold_km  = '1;
    endtask

    task automatic do_init(input bit with_read, input int restart_at, input int abort_at);
        int busy, done, rdy;
        bit aborted;
        busy = 0; done = 0; rdy = 0; aborted = 0;
        init_start = 1'b1;
        if (with_read) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(9);
        end
        @(negedge clk);
        chk("ready_at_init_start", W'(req_ready), W'(0));
        @(posedge clk);
        #1;
        init_start = 1'b0;
        req_valid  = 1'b0;
        for (int i = 0; i < DEPTH + 100; i++) begin
            @(negedge clk);
            if (init_done) done++;
            if (!init_busy) break;
            busy++;
            if (req_ready) rdy++;
            init_start = (busy == restart_at);
            if (busy == abort_at) begin
                rst_n = 1'b0;
                reset_model();
                aborted = 1;
                #1;
                chk("rst_init_busy", W'(init_busy), W'(0));
                chk("rst_init_done", W'(init_done), W'(0));
                chk("rst_rsp_valid", W'(rsp_valid), W'(0));
                chk("rst_req_ready", W'(req_ready), W'(0));
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("ready_after_reset", W'(req_ready), W'(1));
                break;
            end
        end
        init_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (init_done) done++;
        end
        if (aborted) begin
            chk("abort_done_pulses", W'(done), W'(0));
            for (int a = 0; a < 256; a++) mdl_known[a] = '0;
        end else begin
            chk("init_len", W'(busy), W'(DEPTH));
            chk("init_done_pulses", W'(done), W'(1));
            chk("ready_in_init", W'(rdy), W'(0));
            for (int a = 0; a < DEPTH; a++) begin
                mdl_mem[a]   = '0;
                mdl_known[a] = '1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mdl_mem[a]   = '0;
            mdl_known[a] = '0;
        end

        @(negedge clk);
        chk("rst_rsp_valid0", W'(rsp_valid), W'(0));
        chk("rst_rsp_data0", rsp_data, '0);
        chk("rst_init_busy0", W'(init_busy), W'(0));
        chk("rst_init_done0", W'(init_done), W'(0));
        chk("rst_req_ready0", W'(req_ready), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_por", W'(req_ready), W'(1));
        @(posedge clk);
        #1;

        issue(1'b1, AW'(5), '1, {(W/8){8'hA5}});
        issue(1'b0, AW'(5), '0, '0);

        issue(1'b1, AW'(7), '1, '1);
        issue(1'b1, AW'(7), 3'b010, '0);
        issue(1'b0, AW'(7), '0, '0);

        for (int a = 0; a < 8; a++) issue(1'b1, AW'(a), '1, W'(a));
        for (int a = 0; a < 8; a++) issue(1'b0, AW'(a), '0, '0);

        issue(1'b1, AW'(20), 3'b101, rand_word());
        issue(1'b0, AW'(20), '0, '0);
        issue(1'b1, AW'(21), 3'b000, rand_word());
        issue(1'b0, AW'(21), '0, '0);

        for (int n = 0; n < 400; n++) begin
            issue(1'($urandom()), AW'($urandom_range(0, 31)), NS'($urandom()), rand_word());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        issue(1'b0, AW'(3), '0, '0);
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("inflight_rst_valid", W'(rsp_valid), W'(0));
        chk("inflight_rst_data", rsp_data, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), '1, rand_word() | W'(1));
        for (int n = 0; n < 10; n++) issue(1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, '0);

        issue(1'b0, AW'(123), '0, '0);
        do_init(1'b0, 2000, 0);
        for (int n = 0; n < 20; n++) issue(1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, '0);

        do_init(1'b1, 0, 0);
        idle(4);

        issue(1'b1, AW'(4000), '1, rand_word() | W'(1));
        issue(1'b1, AW'(3000), '1, rand_word() | W'(1));
        do_init(1'b0, 0, 100);
        issue(1'b0, AW'(4000), '0, '0);
        issue(1'b0, AW'(3000), '0, '0);
        for (int n = 0; n < 10; n++) issue(1'b0, AW'($urandom_range(256, DEPTH - 1)), '0, '0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("drain", W'(sb.size()), W'(0));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uram_bank_pipe.md
URAM_BANK_PIPE -- requirements
Module: uram_bank_pipe

Interface
- REQ-001: Parameter NUM_SLICES, default 3, number of parallel URAM slices sharing one address.
- REQ-002: Parameter SLICE_WIDTH, default 72, bits per slice word.
- REQ-003: Parameter ADDR_WIDTH, default 12, address bits; depth is 2^ADDR_WIDTH words.
- REQ-004: Parameter RD_LAT, default 2, legal range 1..4, read latency in cycles.
- REQ-005: Local W = NUM_SLICES*SLICE_WIDTH.
- REQ-006: clk  input  1  sole clock, all state on rising edge.
- REQ-007: rst_n  input  1  reset, asynchronous, active-low.
- REQ-008: req_valid  input  1  request present.
- REQ-009: req_ready  output  1  request can be accepted this cycle.
- REQ-010: req_we  input  1  1 = write, 0 = read.
- REQ-011: req_addr  input  ADDR_WIDTH  word address.
- REQ-012: req_wmask  input  NUM_SLICES  per-slice write enable; bit i gates slice i.
- REQ-013: req_wdata  input  W  write data; slice i occupies bits [i*SLICE_WIDTH +: SLICE_WIDTH].
- REQ-014: rsp_valid  output  1  read data valid, one-cycle pulse per read.
- REQ-015: rsp_data  output  W  read data, same slice packing as req_wdata.
- REQ-016: init_start  input  1  start zero-fill of entire bank.
- REQ-017: init_busy  output  1  zero-fill in progress.
- REQ-018: init_done  output  1  one-cycle pulse when zero-fill completes.

Function
- REQ-019: Request accepted on a cycle where req_valid && req_ready; exactly one request per cycle.
- REQ-020: req_ready = 1 only in state IDLE and when init_start is 0 in the same cycle.
- REQ-021: Accepted write updates, in that cycle, only the slices whose req_wmask bit is 1; masked slices keep their contents; all-zero mask is a legal no-op.
- REQ-022: Accepted read raises rsp_valid exactly RD_LAT cycles after acceptance, with rsp_data = stored word at req_addr.
- REQ-023: Reads are pipelined: back-to-back reads produce back-to-back rsp_valid pulses, in order, with no bubbles.
- REQ-024: A read accepted the cycle after a write to the same address returns the newly written data.
- REQ-025: rsp_data holds its last value while rsp_valid = 0.
- REQ-026: FSM states IDLE and INIT; IDLE -> INIT when init_start = 1; INIT -> IDLE after writing the last address.
- REQ-027: In INIT, an address counter starts at 0, writes all-zero to every slice at one address per cycle, and increments to 2^ADDR_WIDTH-1; INIT lasts exactly 2^ADDR_WIDTH cycles.
- REQ-028: init_busy = 1 exactly while in INIT; init_done pulses 1 in the first IDLE cycle after INIT.
- REQ-029: init_start in INIT is ignored; no restart and no counter reset.
- REQ-030: init_start and req_valid in the same IDLE cycle: INIT is entered and the request is not accepted.
- REQ-031: Reads accepted before INIT entry still complete with their scheduled rsp_valid during INIT.
- REQ-032: Memory array contents are not reset; a read of a never-written, never-initialised address returns undefined data.

Reset
- REQ-033: While rst_n = 0: state IDLE, init counter 0, read pipeline valid bits cleared, rsp_valid = 0, rsp_data = 0, init_busy = 0, init_done = 0, req_ready = 0.
- REQ-034: Reset asserted mid-INIT aborts the fill with no init_done pulse, and drops in-flight reads with no rsp_valid.
- REQ-035: First cycle after rst_n deasserts: req_ready = 1 (if init_start = 0).

Verification
- REQ-036: Write addr 5, mask all ones, data A5A5..., then read addr 5 -> rsp_valid exactly RD_LAT cycles after read acceptance, rsp_data = A5A5....
- REQ-037: Write all-ones to addr 7, then write zeros with mask 3'b010, then read addr 7 -> slice 1 = 0, slices 0 and 2 all ones.
- REQ-038: Eight back-to-back reads of addrs 0..7 holding value = addr -> eight consecutive rsp_valid cycles returning 0..7 in order.
- REQ-039: Pulse init_start after filling the bank with nonzero data -> init_busy high for 4096 cycles (ADDR_WIDTH = 12), req_ready low throughout, init_done single pulse, then a read of any address returns 0.
- REQ-040: Assert rst_n = 0 at fill cycle 100, release, then read addr 4000 (preloaded nonzero) -> no init_done pulse, req_ready = 1 after release, read returns the original nonzero data.
- REQ-041: Drive init_start and a read request on the same cycle -> read not accepted, no rsp_valid, INIT entered.
